dcache_nway: RTL and testbench

Parametrised blocking write-back, write-allocate data cache between the LSU and the RAM interface module. It generalises the fixed 2-way cache to WAYS ways, SETS sets and LINE_WORDS words per line, with per-set round-robin replacement, dirty-line writeback and store-miss merge on refill. It processes one request at a time; a load or store hit can be followed by a new request in the next cycle.

---
 rtl/dcache_nway_pkg.sv | 34 +++
 rtl/dcache_nway_way.sv | 66 ++++++
 rtl/dcache_nway.sv | 258 +++++++++++++++++++++++++
 tb/tb_dcache_nway.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_nway_pkg.sv
// Shared types and constants for the N-way write-back data cache.
package dcache_nway_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_WBACK  = 3'd2,
    ST_RDREQ  = 3'd3,
    ST_REFILL = 3'd4
  } state_e;

  localparam logic [2:0] RAM_TYPE_LINE = 3'b100;
  localparam logic [3:0] RAM_WR_EN_ALL = 4'hF;

  // Buffered CPU request held for the whole miss sequence
  typedef struct packed {
    logic        op;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } cpu_req_t;

  // Replace the strobed bytes of old_w with those of new_w
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = strb[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/dcache_nway_way.sv
// One cache way: tag/valid/dirty/data arrays, combinational read, byte-enabled word write.
module dcache_nway_way
  import dcache_nway_pkg::*;
#(
  parameter int unsigned SETS       = 256,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned WORD_W     = 2,
  parameter int unsigned TAG_W      = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IDX_W-1:0]        i_idx,
  input  logic                    i_wr_en,
  input  logic [WORD_W-1:0]       i_wr_word,
  input  logic [31:0]             i_wr_data,
  input  logic [3:0]              i_wr_strb,
  input  logic                    i_set_dirty,
  input  logic                    i_fill,
  input  logic [TAG_W-1:0]        i_fill_tag,
  input  logic                    i_fill_dirty,
  output logic                    o_valid,
  output logic                    o_dirty,
  output logic [TAG_W-1:0]        o_tag,
  output logic [32*LINE_WORDS-1:0] o_line
);

  logic [SETS-1:0]  r_valid;
  logic [SETS-1:0]  r_dirty;
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [31:0]      r_data [SETS][LINE_WORDS];

  // Tag and data storage; contents are meaningless until valid is set
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[i_idx][i_wr_word] <= merge_bytes(r_data[i_idx][i_wr_word], i_wr_data, i_wr_strb);
    end
    if (i_fill) begin
      r_tag[i_idx] <= i_fill_tag;
    end
  end

  // Valid/dirty bits, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= i_fill_dirty;
    end else if (i_set_dirty) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // Combinational read of the indexed set
  always_comb begin
    o_valid = r_valid[i_idx];
    o_dirty = r_dirty[i_idx];
    o_tag   = r_tag[i_idx];
    for (int i = 0; i < LINE_WORDS; i++) begin
      o_line[i*32 +: 32] = r_data[i_idx][i];
    end
  end

endmodule

// File: rtl/dcache_nway.sv
// Blocking write-back, write-allocate N-way data cache between LSU and RAM interface.
// Optional DCACHE_NWAY_PERF_EN adds saturating first-lookup hit/miss counters.
module dcache_nway
  import dcache_nway_pkg::*;
#(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 256,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req_i,
  input  logic                     cpu_op_i,
  input  logic [31:0]              cpu_addr_i,
  input  logic [3:0]               cpu_wstrb_i,
  input  logic [31:0]              cpu_wdata_i,
  output logic [31:0]              cpu_rdata_o,
  output logic                     cpu_addr_ack_o,
  output logic                     cpu_data_ack_o,
  output logic                     ram_rd_req_o,
  output logic [2:0]               ram_rd_type_o,
  output logic [31:0]              ram_rd_addr_o,
  input  logic                     ram_rd_rdy_i,
  input  logic [31:0]              ram_rd_data_i,
  input  logic                     ram_rd_valid_i,
  input  logic                     ram_rd_last_i,
  output logic                     ram_wr_req_o,
  output logic [2:0]               ram_wr_type_o,
  output logic [3:0]               ram_wr_en_o,
  output logic [31:0]              ram_wr_addr_o,
  output logic [32*LINE_WORDS-1:0] ram_wr_data_o,
  input  logic                     ram_wr_rdy_i
`ifdef DCACHE_NWAY_PERF_EN
  ,
  output logic [31:0]              hit_cnt_o,
  output logic [31:0]              miss_cnt_o
`endif
);

  localparam int unsigned OFF_W  = $clog2(LINE_WORDS) + 2;
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W;
  localparam int unsigned WORD_W = $clog2(LINE_WORDS);
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned LINE_W = 32 * LINE_WORDS;

  state_e              r_state;
  state_e              w_next;
  cpu_req_t            r_req;
  logic [WAY_W-1:0]    r_victim;
  logic [WORD_W-1:0]   r_beat;

  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_idx;
  logic [WORD_W-1:0]   w_word;
  logic                w_unused_addr;

  logic [WAYS-1:0]     w_way_valid;
  logic [WAYS-1:0]     w_way_dirty;
  logic [TAG_W-1:0]    w_way_tag  [WAYS];
  logic [LINE_W-1:0]   w_way_line [WAYS];
  logic [WAYS-1:0]     w_way_we;
  logic [WAYS-1:0]     w_way_set_dirty;
  logic [WAYS-1:0]     w_way_fill;

  logic [WAYS-1:0]     w_hit_vec;
  logic                w_hit_any;
  logic [WAY_W-1:0]    w_hit_way;
  logic [31:0]         w_hit_word;
  logic                w_miss;
  logic                w_inv_found;
  logic [WAY_W-1:0]    w_inv_way;
  logic [WAY_W-1:0]    w_rr_cur;
  logic [WAY_W-1:0]    w_miss_victim;
  logic                w_refill_beat;
  logic [31:0]         w_beat_data;
  logic [WORD_W-1:0]   w_wr_word;
  logic [31:0]         w_wr_data;
  logic [3:0]          w_wr_strb;

  assign w_tag         = r_req.addr[31 -: TAG_W];
  assign w_idx         = r_req.addr[OFF_W +: IDX_W];
  assign w_word        = r_req.addr[2 +: WORD_W];
  assign w_unused_addr = ^r_req.addr[1:0];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    dcache_nway_way #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS),
      .IDX_W      (IDX_W),
      .WORD_W     (WORD_W),
      .TAG_W      (TAG_W)
    ) u_way (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_idx        (w_idx),
      .i_wr_en      (w_way_we[g]),
      .i_wr_word    (w_wr_word),
      .i_wr_data    (w_wr_data),
      .i_wr_strb    (w_wr_strb),
      .i_set_dirty  (w_way_set_dirty[g]),
      .i_fill       (w_way_fill[g]),
      .i_fill_tag   (w_tag),
      .i_fill_dirty (r_req.op),
      .o_valid      (w_way_valid[g]),
      .o_dirty      (w_way_dirty[g]),
      .o_tag        (w_way_tag[g]),
      .o_line       (w_way_line[g])
    );
  end

  // Tag compare, hit word select and victim choice for the buffered request
  always_comb begin
    w_hit_vec   = '0;
    w_hit_way   = '0;
    w_hit_word  = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_way_valid[w] && (w_way_tag[w] == w_tag)) begin
        w_hit_vec[w] = 1'b1;
        w_hit_way    = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_way_valid[w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
    end
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (WORD_W'(i) == w_word) begin
        w_hit_word = w_way_line[w_hit_way][i*32 +: 32];
      end
    end
    w_hit_any     = |w_hit_vec;
    w_miss_victim = w_inv_found ? w_inv_way : w_rr_cur;
  end

  // Next-state and handshake decode
  always_comb begin
    w_next         = r_state;
    cpu_addr_ack_o = 1'b0;
    cpu_data_ack_o = 1'b0;
    ram_rd_req_o   = 1'b0;
    ram_wr_req_o   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        cpu_addr_ack_o = cpu_req_i;
        if (cpu_req_i) w_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (w_hit_any) begin
          cpu_data_ack_o = 1'b1;
          cpu_addr_ack_o = cpu_req_i;
          w_next         = cpu_req_i ? ST_LOOKUP : ST_IDLE;
        end else if (w_way_valid[w_miss_victim] && w_way_dirty[w_miss_victim]) begin
          w_next = ST_WBACK;
        end else begin
          w_next = ST_RDREQ;
        end
      end
      ST_WBACK: begin
        ram_wr_req_o = 1'b1;
        if (ram_wr_rdy_i) w_next = ST_RDREQ;
      end
      ST_RDREQ: begin
        ram_rd_req_o = 1'b1;
        if (ram_rd_rdy_i) w_next = ST_REFILL;
      end
      ST_REFILL: begin
        if (ram_rd_valid_i && ram_rd_last_i) w_next = ST_LOOKUP;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Way write steering: store hits and refill beats share one write port per way
  always_comb begin
    w_miss        = (r_state == ST_LOOKUP) && !w_hit_any;
    w_refill_beat = (r_state == ST_REFILL) && ram_rd_valid_i;
    w_beat_data   = (r_req.op && (r_beat == w_word))
                    ? merge_bytes(ram_rd_data_i, r_req.wdata, r_req.wstrb) : ram_rd_data_i;
    w_wr_word     = w_refill_beat ? r_beat      : w_word;
    w_wr_data     = w_refill_beat ? w_beat_data : r_req.wdata;
    w_wr_strb     = w_refill_beat ? RAM_WR_EN_ALL : r_req.wstrb;
    for (int w = 0; w < WAYS; w++) begin
      w_way_set_dirty[w] = cpu_data_ack_o && r_req.op && w_hit_vec[w];
      w_way_we[w]        = w_way_set_dirty[w] || (w_refill_beat && (r_victim == WAY_W'(w)));
      w_way_fill[w]      = w_refill_beat && ram_rd_last_i && (r_victim == WAY_W'(w));
    end
  end

  // Request buffer, victim latch and refill beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req    <= '0;
      r_victim <= '0;
      r_beat   <= '0;
    end else begin
      if (cpu_addr_ack_o) r_req <= cpu_req_t'({cpu_op_i, cpu_addr_i, cpu_wstrb_i, cpu_wdata_i});
      if (w_miss) r_victim <= w_miss_victim;
      if (r_state == ST_RDREQ)  r_beat <= '0;
      else if (w_refill_beat)   r_beat <= r_beat + WORD_W'(1);
    end
  end

  if (WAYS > 1) begin : g_rr
    logic [WAY_W-1:0] r_rr [SETS];

    // Per-set round-robin pointer, advanced only when no invalid way was free
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
      end else if (w_miss && !w_inv_found) begin
        r_rr[w_idx] <= r_rr[w_idx] + WAY_W'(1);
      end
    end
    assign w_rr_cur = r_rr[w_idx];
  end else begin : g_no_rr
    assign w_rr_cur = '0;
  end

  assign cpu_rdata_o   = cpu_data_ack_o ? w_hit_word : 32'h0;
  assign ram_rd_type_o = RAM_TYPE_LINE;
  assign ram_wr_type_o = RAM_TYPE_LINE;
  assign ram_wr_en_o   = RAM_WR_EN_ALL;
  assign ram_rd_addr_o = ram_rd_req_o ? {r_req.addr[31:OFF_W], OFF_W'(0)} : 32'h0;
  assign ram_wr_addr_o = ram_wr_req_o ? {w_way_tag[r_victim], w_idx, OFF_W'(0)} : 32'h0;
  assign ram_wr_data_o = ram_wr_req_o ? w_way_line[r_victim] : '0;

`ifdef DCACHE_NWAY_PERF_EN
  logic r_first;

  // Count only lookups of freshly accepted requests, not post-refill re-lookups
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first    <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (cpu_addr_ack_o) r_first <= 1'b1;
      else if (r_state == ST_LOOKUP) r_first <= 1'b0;
      if ((r_state == ST_LOOKUP) && r_first) begin
        if (w_hit_any && (hit_cnt_o != 32'hFFFF_FFFF))   hit_cnt_o  <= hit_cnt_o + 32'd1;
        if (!w_hit_any && (miss_cnt_o != 32'hFFFF_FFFF)) miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_nway.sv
// Self-checking bench for dcache_nway (WAYS=2, SETS=4, LINE_WORDS=4): directed steps then random traffic.
module tb_dcache_nway;

  localparam int unsigned WAYS       = 2;
  localparam int unsigned SETS       = 4;
  localparam int unsigned LINE_WORDS = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_req = 1'b0;
  logic         cpu_op = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [3:0]   cpu_wstrb = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_addr_ack_o, cpu_data_ack_o;
  logic         ram_rd_req_o;
  logic [2:0]   ram_rd_type_o, ram_wr_type_o;
  logic [31:0]  ram_rd_addr_o, ram_wr_addr_o;
  logic         ram_rd_rdy = 1'b0;
  logic [31:0]  ram_rd_data = '0;
  logic         ram_rd_valid = 1'b0;
  logic         ram_rd_last = 1'b0;
  logic         ram_wr_req_o;
  logic [3:0]   ram_wr_en_o;
  logic [127:0] ram_wr_data_o;
  logic         ram_wr_rdy = 1'b0;

  always #5 clk = ~clk;

  dcache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req), .cpu_op_i(cpu_op), .cpu_addr_i(cpu_addr),
    .cpu_wstrb_i(cpu_wstrb), .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata_o),
    .cpu_addr_ack_o(cpu_addr_ack_o), .cpu_data_ack_o(cpu_data_ack_o),
    .ram_rd_req_o(ram_rd_req_o), .ram_rd_type_o(ram_rd_type_o), .ram_rd_addr_o(ram_rd_addr_o),
    .ram_rd_rdy_i(ram_rd_rdy), .ram_rd_data_i(ram_rd_data), .ram_rd_valid_i(ram_rd_valid),
    .ram_rd_last_i(ram_rd_last), .ram_wr_req_o(ram_wr_req_o), .ram_wr_type_o(ram_wr_type_o),
    .ram_wr_en_o(ram_wr_en_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o),
    .ram_wr_rdy_i(ram_wr_rdy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Backing memory and the architectural (program-order) view, keyed by word address
  bit [31:0] ram  [int];
  bit [31:0] arch [int];

  // Which lines the cache holds per set, with replacement state
  bit m_valid [SETS][WAYS];
  bit m_dirty [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  int m_rr    [SETS];

  logic [31:0]  g_rdata;
  logic [127:0] g_wb_data;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] ram_rd(input int wa);
    if (ram.exists(wa)) return ram[wa];
    return (32'(wa) * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic bit [31:0] arch_rd(input int wa);
    if (arch.exists(wa)) return arch[wa];
    return ram_rd(wa);
  endfunction

  // Cache contents are lost on reset; memory keeps whatever was written back
  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = 0;
      end
    end
    arch.delete();
  endtask

  // One complete request with a RAM responder; predicts hit/miss/writeback and data
  task automatic access(input bit op, input logic [31:0] addr, input logic [3:0] wstrb,
                        input logic [31:0] wdata, input int wdly, input string tag);
    int s, t, v, wb_line, base, beat, wcnt, rcnt;
    bit hit, exp_wb, wb_seen, rd_seen, done;
    logic [127:0] exp_wb_data;
    logic [31:0] mask, exp_rd;
    s = int'((addr >> 4) % SETS);
    t = int'(addr >> 6);
    base = int'(addr >> 4) * 4;
    hit = 1'b0; v = 0; exp_wb = 1'b0; wb_line = 0; exp_wb_data = '0;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) begin hit = 1'b1; v = w; end
    if (!hit) begin
      v = -1;
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
      if (v < 0) begin v = m_rr[s]; m_rr[s] = (m_rr[s] + 1) % WAYS; end
      exp_wb  = m_valid[s][v] && m_dirty[s][v];
      wb_line = m_tag[s][v] * 16 + s * 4;
      for (int i = 0; i < 4; i++) exp_wb_data[i*32 +: 32] = arch_rd(wb_line + i);
      m_valid[s][v] = 1'b1;
      m_tag[s][v]   = t;
      m_dirty[s][v] = op;
    end else if (op) begin
      m_dirty[s][v] = 1'b1;
    end
    if (op) begin
      for (int b = 0; b < 4; b++) mask[b*8 +: 8] = wstrb[b] ? 8'hFF : 8'h00;
      arch[int'(addr >> 2)] = (arch_rd(int'(addr >> 2)) & ~mask) | (wdata & mask);
    end
    exp_rd = arch_rd(int'(addr >> 2));

    @(negedge clk);
    cpu_req = 1'b1; cpu_op = op; cpu_addr = addr; cpu_wstrb = wstrb; cpu_wdata = wdata;
    #1;
    chk({tag, "_addr_ack"}, 128'(cpu_addr_ack_o), 128'(1));
    wb_seen = 1'b0; rd_seen = 1'b0; done = 1'b0; beat = 0;
    wcnt = wdly; rcnt = int'($urandom_range(0, 2));
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      cpu_req = 1'b0; ram_wr_rdy = 1'b0; ram_rd_rdy = 1'b0;
      ram_rd_valid = 1'b0; ram_rd_last = 1'b0; ram_rd_data = $urandom;
      #1;
      if (cpu_data_ack_o) begin
        done = 1'b1;
        g_rdata = cpu_rdata_o;
        if (!op) chk({tag, "_rdata"}, 128'(cpu_rdata_o), 128'(exp_rd));
      end else if (ram_wr_req_o) begin
        if (!wb_seen) begin
          chk({tag, "_wb_addr"}, 128'(ram_wr_addr_o), 128'(wb_line * 4));
          chk({tag, "_wb_data"}, ram_wr_data_o, exp_wb_data);
          g_wb_data = ram_wr_data_o;
        end
        wb_seen = 1'b1;
        if (wcnt == 0) begin
          ram_wr_rdy = 1'b1;
          for (int i = 0; i < 4; i++) ram[wb_line + i] = exp_wb_data[i*32 +: 32];
        end else wcnt--;
      end else if (ram_rd_req_o) begin
        if (!rd_seen) chk({tag, "_rd_addr"}, 128'(ram_rd_addr_o), 128'(base * 4));
        rd_seen = 1'b1;
        if (rcnt == 0) ram_rd_rdy = 1'b1; else rcnt--;
      end else if (rd_seen && beat < 4 && $urandom_range(0, 3) != 0) begin
        ram_rd_valid = 1'b1;
        ram_rd_data  = ram_rd(base + beat);
        ram_rd_last  = (beat == 3);
        beat++;
      end
    end
    ram_rd_valid = 1'b0; ram_rd_last = 1'b0;
    chk({tag, "_done"}, 128'(done), 128'(1));
    chk({tag, "_wb_seen"}, 128'(wb_seen), 128'(exp_wb));
    chk({tag, "_miss"}, 128'(rd_seen), 128'(!hit));
  endtask

  initial begin
    int beat;
    bit rd_seen;
    logic [31:0] a;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_addr_ack", 128'(cpu_addr_ack_o), 128'(0));
    chk("rst_data_ack", 128'(cpu_data_ack_o), 128'(0));
    chk("rst_rdata", 128'(cpu_rdata_o), 128'(0));
    chk("rst_rd_req", 128'(ram_rd_req_o), 128'(0));
    chk("rst_rd_addr", 128'(ram_rd_addr_o), 128'(0));
    chk("rst_wr_req", 128'(ram_wr_req_o), 128'(0));
    chk("rst_wr_addr", 128'(ram_wr_addr_o), 128'(0));
    chk("rst_wr_data", ram_wr_data_o, 128'(0));
    chk("rst_rd_type", 128'(ram_rd_type_o), 128'(3'b100));
    chk("rst_wr_type", 128'(ram_wr_type_o), 128'(3'b100));
    chk("rst_wr_en", 128'(ram_wr_en_o), 128'(4'hF));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    ram[32'h40] = 32'h11; ram[32'h41] = 32'h22; ram[32'h42] = 32'h33; ram[32'h43] = 32'h44;

    // Clean miss then refill
    access(1'b0, 32'h104, 4'h0, 32'h0, 0, "tp1");
    chk("tp1_const", 128'(g_rdata), 128'(32'h22));

    // Back-to-back load hits
    @(negedge clk);
    cpu_req = 1'b1; cpu_op = 1'b0; cpu_addr = 32'h108; #1;
    chk("b2b_ack0", 128'(cpu_addr_ack_o), 128'(1));
    @(negedge clk);
    cpu_addr = 32'h10C; #1;
    chk("b2b_dack0", 128'(cpu_data_ack_o), 128'(1));
    chk("b2b_rdata0", 128'(cpu_rdata_o), 128'(32'h33));
    chk("b2b_ack1", 128'(cpu_addr_ack_o), 128'(1));
    @(negedge clk);
    cpu_req = 1'b0; #1;
    chk("b2b_dack1", 128'(cpu_data_ack_o), 128'(1));
    chk("b2b_rdata1", 128'(cpu_rdata_o), 128'(32'h44));
    chk("b2b_no_ram", 128'({ram_rd_req_o, ram_wr_req_o}), 128'(0));

    // Store hit then load
    access(1'b1, 32'h100, 4'b0011, 32'hAAAA_BBBB, 0, "tp3_st");
    access(1'b0, 32'h100, 4'h0, 32'h0, 0, "tp3_ld");
    chk("tp3_const", 128'(g_rdata), 128'(32'h0000_BBBB));

    // Dirty eviction with writeback held off for three cycles
    access(1'b0, 32'h200, 4'h0, 32'h0, 0, "tp4_fill");
    access(1'b0, 32'h300, 4'h0, 32'h0, 3, "tp4_evict");
    chk("tp4_wb_const", g_wb_data, 128'h00000044_00000033_00000022_0000BBBB);

    // Store miss merged into the refill
    access(1'b1, 32'h404, 4'hF, 32'hDEAD_BEEF, 0, "tp5_st");
    access(1'b0, 32'h404, 4'h0, 32'h0, 0, "tp5_ld");
    chk("tp5_const", 128'(g_rdata), 128'(32'hDEAD_BEEF));

    // Reset after the second refill beat
    @(negedge clk);
    cpu_req = 1'b1; cpu_op = 1'b0; cpu_addr = 32'h1010; #1;
    chk("rstmid_ack", 128'(cpu_addr_ack_o), 128'(1));
    beat = 0; rd_seen = 1'b0;
    for (int c = 0; c < 50 && beat < 2; c++) begin
      @(negedge clk);
      cpu_req = 1'b0; ram_rd_rdy = 1'b0; ram_rd_valid = 1'b0; ram_rd_last = 1'b0;
      #1;
      if (ram_rd_req_o) begin
        rd_seen = 1'b1; ram_rd_rdy = 1'b1;
      end else if (rd_seen) begin
        ram_rd_valid = 1'b1; ram_rd_data = ram_rd(32'h404 + beat); beat++;
      end
    end
    chk("rstmid_beats", 128'(beat), 128'(2));
    @(negedge clk);
    ram_rd_valid = 1'b0; rst_n = 1'b0; #1;
    chk("rstmid_outs", 128'({cpu_addr_ack_o, cpu_data_ack_o, ram_rd_req_o, ram_wr_req_o}), 128'(0));
    chk("rstmid_rd_addr", 128'(ram_rd_addr_o), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    access(1'b0, 32'h1010, 4'h0, 32'h0, 0, "rstmid_reload");

    // Random traffic over a small footprint to force conflicts and evictions
    for (int n = 0; n < 150; n++) begin
      a = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 4)
        | (32'($urandom_range(0, 3)) << 2);
      access(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom,
             int'($urandom_range(0, 3)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
